control_unit: RTL

Hardwired control sequencer for the bus-architecture datapath. It steps through the fetch and execute cycles and drives every datapath strobe: register-in and register-out enables, ALU operation selects, Read and IncPC. It decodes the instruction register value that the datapath returns, so it takes over the role a directed bench plays when it hand-drives those strobes. It instantiates alongside `datapath` in the processor top level, one output per datapath control input.

---
 rtl/cu_pkg.sv | 52 +++++
 rtl/ir_decode.sv | 55 +++++
 rtl/control_unit.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/cu_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, IR field positions,
// FSM state encoding and instruction classes.
package cu_pkg;

    localparam int unsigned OpcodeMsb = 31;
    localparam int unsigned OpcodeLsb = 27;
    localparam int unsigned RaMsb     = 26;
    localparam int unsigned RaLsb     = 23;
    localparam int unsigned RbMsb     = 22;
    localparam int unsigned RbLsb     = 19;
    localparam int unsigned RcMsb     = 18;
    localparam int unsigned RcLsb     = 15;

    localparam logic [4:0] OpAdd  = 5'd3;
    localparam logic [4:0] OpSub  = 5'd4;
    localparam logic [4:0] OpShr  = 5'd5;
    localparam logic [4:0] OpShl  = 5'd6;
    localparam logic [4:0] OpRor  = 5'd7;
    localparam logic [4:0] OpRol  = 5'd8;
    localparam logic [4:0] OpAnd  = 5'd9;
    localparam logic [4:0] OpOr   = 5'd10;
    localparam logic [4:0] OpMul  = 5'd14;
    localparam logic [4:0] OpDiv  = 5'd15;
    localparam logic [4:0] OpNeg  = 5'd16;
    localparam logic [4:0] OpNot  = 5'd17;
    localparam logic [4:0] OpIn   = 5'd21;
    localparam logic [4:0] OpOut  = 5'd22;
    localparam logic [4:0] OpNop  = 5'd25;
    localparam logic [4:0] OpHalt = 5'd26;

    typedef enum logic [3:0] {
        StRst  = 4'd0,
        StT0   = 4'd1,
        StT1   = 4'd2,
        StT2   = 4'd3,
        StT3   = 4'd4,
        StT4   = 4'd5,
        StT5   = 4'd6,
        StHalt = 4'd7
    } state_e;

    typedef enum logic [2:0] {
        ClsNop,
        ClsAlu,
        ClsMulDiv,
        ClsNegNot,
        ClsIn,
        ClsOut,
        ClsHalt
    } instr_cls_e;

endpackage

// File: rtl/ir_decode.sv
// Combinational IR decode: opcode, instruction class and masked one-hot register selects.
// CONTROL_UNIT_MULDIV_EN: when undefined, mul/div opcodes decode as nop.
module ir_decode
    import cu_pkg::*;
#(
    parameter int unsigned BITS      = 32,
    parameter int unsigned REGISTERS = 16
) (
    input  logic [BITS-1:0]      IRVal,
    output logic [4:0]           opcode,
    output instr_cls_e           cls,
    output logic [REGISTERS-1:0] ra_oh,
    output logic [REGISTERS-1:0] rb_oh,
    output logic [REGISTERS-1:0] rc_oh
);

    logic [3:0] ra, rb, rc;
    logic       unused_ir;

    assign opcode    = IRVal[OpcodeMsb:OpcodeLsb];
    assign ra        = IRVal[RaMsb:RaLsb];
    assign rb        = IRVal[RbMsb:RbLsb];
    assign rc        = IRVal[RcMsb:RcLsb];
    assign unused_ir = ^IRVal;

    // Fields that name a register beyond REGISTERS simply match no bit.
    always_comb begin
        ra_oh = '0;
        rb_oh = '0;
        rc_oh = '0;
        for (int unsigned i = 0; i < REGISTERS; i++) begin
            ra_oh[i] = (32'(ra) == i);
            rb_oh[i] = (32'(rb) == i);
            rc_oh[i] = (32'(rc) == i);
        end
    end

    always_comb begin
        cls = ClsNop;
        case (opcode)
            OpAdd, OpSub, OpShr, OpShl, OpRor, OpRol, OpAnd, OpOr: cls = ClsAlu;
`ifdef CONTROL_UNIT_MULDIV_EN
            OpMul, OpDiv: cls = ClsMulDiv;
`else
            OpMul, OpDiv: cls = ClsNop;
`endif
            OpNeg, OpNot: cls = ClsNegNot;
            OpIn:         cls = ClsIn;
            OpOut:        cls = ClsOut;
            OpHalt:       cls = ClsHalt;
            default:      cls = ClsNop;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired fetch/execute sequencer driving every datapath strobe from state and IRVal.
// CONTROL_UNIT_MULDIV_EN enables the mul/div sequence; otherwise MUL, DIV, HILOin stay 0.
module control_unit
    import cu_pkg::*;
#(
    parameter int unsigned BITS      = 32,
    parameter int unsigned REGISTERS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BITS-1:0]      IRVal,
    output logic [REGISTERS-1:0] GPRin,
    output logic [REGISTERS-1:0] GPRout,
    output logic                 PCin, IRin, RYin, RZin, MARin, HILOin, MDRin, OUTPUTin,
    output logic                 Read, INPUTout, MDRout, HILOout, RZout, PCout, BAout,
    output logic                 ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR,
    output logic                 NEGATE, NOT, IncPC,
    output logic                 run
);

    state_e               state_q, state_d;
    logic [4:0]           opcode;
    instr_cls_e           cls;
    logic [REGISTERS-1:0] ra_oh, rb_oh, rc_oh;

    ir_decode #(
        .BITS      (BITS),
        .REGISTERS (REGISTERS)
    ) u_ir_decode (
        .IRVal  (IRVal),
        .opcode (opcode),
        .cls    (cls),
        .ra_oh  (ra_oh),
        .rb_oh  (rb_oh),
        .rc_oh  (rc_oh)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= StRst;
        else       state_q <= state_d;
    end

    assign BAout   = 1'b0;
    assign HILOout = 1'b0;
    assign run     = (state_q != StRst) && (state_q != StHalt);

    always_comb begin
        state_d  = state_q;
        GPRin    = '0;
        GPRout   = '0;
        {PCin, IRin, RYin, RZin, MARin, HILOin, MDRin, OUTPUTin} = '0;
        {Read, INPUTout, MDRout, RZout, PCout} = '0;
        {ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT, IncPC} = '0;

        case (state_q)
            StRst: state_d = StT0;
            StT0: begin
                {PCout, MARin, IncPC, RZin} = '1;
                state_d = StT1;
            end
            StT1: begin
                {Read, MDRin, RZout, PCin} = '1;
                state_d = StT2;
            end
            StT2: begin
                {MDRout, IRin} = '1;
                case (cls)
                    ClsNop:  state_d = StT0;
                    ClsHalt: state_d = StHalt;
                    default: state_d = StT3;
                endcase
            end
            StT3: begin
                state_d = StT0;
                case (cls)
                    ClsAlu, ClsMulDiv: begin
                        GPRout  = rb_oh;
                        RYin    = 1'b1;
                        state_d = StT4;
                    end
                    ClsNegNot: begin
                        GPRout  = rb_oh;
                        RZin    = 1'b1;
                        NEGATE  = (opcode == OpNeg);
                        NOT     = (opcode == OpNot);
                        state_d = StT4;
                    end
                    ClsIn: begin
                        INPUTout = 1'b1;
                        GPRin    = ra_oh;
                    end
                    ClsOut: begin
                        GPRout   = ra_oh;
                        OUTPUTin = 1'b1;
                    end
                    default: ;
                endcase
            end
            StT4: begin
                state_d = StT0;
                case (cls)
                    ClsAlu: begin
                        GPRout  = rc_oh;
                        RZin    = 1'b1;
                        state_d = StT5;
                        case (opcode)
                            OpAdd:   ADD = 1'b1;
                            OpSub:   SUB = 1'b1;
                            OpShr:   SHR = 1'b1;
                            OpShl:   SHL = 1'b1;
                            OpRor:   ROR = 1'b1;
                            OpRol:   ROL = 1'b1;
                            OpAnd:   AND = 1'b1;
                            OpOr:    OR  = 1'b1;
                            default: ;
                        endcase
                    end
`ifdef CONTROL_UNIT_MULDIV_EN
                    ClsMulDiv: begin
                        GPRout  = rc_oh;
                        RZin    = 1'b1;
                        MUL     = (opcode == OpMul);
                        DIV     = (opcode == OpDiv);
                        state_d = StT5;
                    end
`endif
                    ClsNegNot: begin
                        RZout = 1'b1;
                        GPRin = ra_oh;
                    end
                    default: ;
                endcase
            end
            StT5: begin
                state_d = StT0;
                case (cls)
                    ClsAlu: begin
                        RZout = 1'b1;
                        GPRin = ra_oh;
                    end
`ifdef CONTROL_UNIT_MULDIV_EN
                    ClsMulDiv: HILOin = 1'b1;
`endif
                    default: ;
                endcase
            end
            StHalt:  state_d = StHalt;
            default: state_d = StRst;
        endcase
    end

endmodule
